// File: rtl/obstacle_texture_mem.sv
// 4096x12 texel memory for the obstacle drawing stage: 1-cycle read-first read port,
// streaming load port, optional self-fill with a checker texture (TEXTURE_INIT_EN).
module obstacle_texture_mem #(
    parameter logic [11:0] CHECK_HI = 12'h888,
    parameter logic [11:0] CHECK_LO = 12'h444
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] pixel_addr_i,
    output logic [11:0] rgb_pixel_o,
    input  logic        load_start_i,
    input  logic        load_valid_i,
    input  logic [11:0] load_data_i,
    output logic        load_ready_o,
    output logic        load_done_o,
    output logic        init_done_o
);

`ifdef TEXTURE_INIT_EN
    localparam logic [1:0] ST_INIT = 2'd0;
`endif
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

`ifdef TEXTURE_INIT_EN
    localparam logic [1:0] ST_RESET = ST_INIT;
`else
    localparam logic [1:0] ST_RESET = ST_IDLE;
`endif

    logic [11:0] mem_q [4096];

    logic [1:0]  state_q, state_d;
    logic [11:0] wptr_q, wptr_d;
    logic        init_done_q, init_done_d;
    logic        load_ready_q, load_ready_d;
    logic        load_done_q, load_done_d;
    logic [11:0] rgb_pixel_q;
    logic        wr_en;
    logic [11:0] wr_data;
    logic        xfer;

    assign xfer = load_valid_i && load_ready_q;

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        init_done_d  = init_done_q;
        load_ready_d = load_ready_q;
        load_done_d  = 1'b0;
        wr_en        = 1'b0;
        wr_data      = load_data_i;
`ifndef TEXTURE_INIT_EN
        init_done_d  = 1'b1;
`endif
        case (state_q)
`ifdef TEXTURE_INIT_EN
            ST_INIT: begin
                wr_en   = 1'b1;
                wr_data = (wptr_q[9] ^ wptr_q[3]) ? CHECK_HI : CHECK_LO;
                wptr_d  = wptr_q + 12'd1;
                if (wptr_q == 12'hFFF) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
`endif
            ST_IDLE: begin
                if (load_start_i) begin
                    state_d      = ST_LOAD;
                    wptr_d       = 12'd0;
                    load_ready_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    wr_en  = 1'b1;
                    wptr_d = wptr_q + 12'd1;
                    if (wptr_q == 12'hFFF) begin
                        state_d      = ST_IDLE;
                        load_ready_d = 1'b0;
                        load_done_d  = 1'b1;
                    end
                end
                // A restart wins over completion: the texel is kept, the load begins again.
                if (load_start_i) begin
                    state_d      = ST_LOAD;
                    wptr_d       = 12'd0;
                    load_ready_d = 1'b1;
                    load_done_d  = 1'b0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                load_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RESET;
            wptr_q       <= 12'd0;
            init_done_q  <= 1'b0;
            load_ready_q <= 1'b0;
            load_done_q  <= 1'b0;
            rgb_pixel_q  <= 12'h000;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            init_done_q  <= init_done_d;
            load_ready_q <= load_ready_d;
            load_done_q  <= load_done_d;
`ifdef TEXTURE_INIT_EN
            rgb_pixel_q  <= init_done_q ? mem_q[pixel_addr_i] : 12'h000;
`else
            rgb_pixel_q  <= mem_q[pixel_addr_i];
`endif
        end
    end

    assign rgb_pixel_o  = rgb_pixel_q;
    assign load_ready_o = load_ready_q;
    assign load_done_o  = load_done_q;
    assign init_done_o  = init_done_q;

endmodule
